// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and address helpers for the scoreboarded register file.
package reg_file_sb_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;

   // Address width for a register count (at least one bit).
   function automatic int unsigned addr_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // True when an address names a real, writable register.
   function automatic logic addr_valid(input int unsigned a,
                                       input int unsigned nreg,
                                       input int unsigned zero_r0);
      return (a < nreg) && !((zero_r0 != 0) && (a == 0));
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Load-pending bits per register plus a registered population count.
module rf_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter  int unsigned NREG    = NREG_DEF,
   parameter  int unsigned ZERO_R0 = 1,
   localparam int unsigned AW      = addr_width(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sb_set,
   input  logic [AW-1:0]   sb_addr,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   output logic [NREG-1:0] pend_o,
   output logic [AW:0]     pend_cnt_o
);

   logic [NREG-1:0] pend_q, pend_d;
   logic [AW:0]     cnt_q, cnt_d;

   // Writeback clears, issue sets; set is applied last so it wins a collision.
   always_comb begin
      pend_d = pend_q;
      if (wr_en && addr_valid(32'(wr_addr), NREG, ZERO_R0)) pend_d[wr_addr] = 1'b0;
      if (sb_set && addr_valid(32'(sb_addr), NREG, ZERO_R0)) pend_d[sb_addr] = 1'b1;
      cnt_d = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d = cnt_d + (AW+1)'(pend_d[r]);
      end
   end

   // Pending bits and their count move together on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_o     = pend_q;
   assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write bypass and load-pending scoreboard.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter  int unsigned XLEN    = XLEN_DEF,
   parameter  int unsigned NREG    = NREG_DEF,
   parameter  int unsigned NRP     = 2,
   parameter  int unsigned ZERO_R0 = 1,
   parameter  int unsigned BYPASS  = 1,
   localparam int unsigned AW      = addr_width(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRP*AW-1:0]   rd_addr,
   output logic [NRP*XLEN-1:0] rd_data,
   output logic [NRP-1:0]      rd_pend,
   input  logic [NRP-1:0]      rd_use,
   output logic                stall,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_addr,
   output logic [AW:0]         pend_cnt,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pend;
   logic            wr_ok;

   assign wr_ok = wr_en && addr_valid(32'(wr_addr), NREG, ZERO_R0);

   // Next array contents: only legal writeback addresses update.
   always_comb begin
      regs_d = regs_q;
      if (wr_ok) regs_d[wr_addr] = wr_data;
   end

   // Data array register; reset overrides any same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end

   rf_scoreboard #(
      .NREG    (NREG),
      .ZERO_R0 (ZERO_R0)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .sb_set     (sb_set),
      .sb_addr    (sb_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .pend_o     (pend),
      .pend_cnt_o (pend_cnt)
   );

   for (genvar i = 0; i < NRP; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_c;
      logic            hit_c;
      logic            pend_c;

      assign addr = rd_addr[i*AW +: AW];

      // Read mux with forwarding; a forwarded writeback also hides the pending bit
      // unless an issue to the same register re-arms it in this cycle.
      always_comb begin
         data_c = '0;
         pend_c = 1'b0;
         hit_c  = (BYPASS != 0) && wr_ok && (wr_addr == addr);
         if (!rst && addr_valid(32'(addr), NREG, ZERO_R0)) begin
            data_c = hit_c ? wr_data : regs_q[addr];
            pend_c = pend[addr] && !(hit_c && !(sb_set && (sb_addr == addr)));
         end
      end

      assign rd_data[i*XLEN +: XLEN] = data_c;
      assign rd_pend[i]              = pend_c;
   end

   assign stall = |(rd_pend & rd_use);

   // Raw array view for debug, never forwarded.
   always_comb begin
      dbg_data = '0;
      if (!rst && (32'(dbg_addr) < NREG)) dbg_data = regs_q[dbg_addr];
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed table plus randomized traffic against a reference model.
module tb_reg_file_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NRP  = 2;
   localparam int unsigned AW   = 5;
   localparam int unsigned NDUT = 2;
   localparam int unsigned NTV  = 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, wr_en, sb_set;
   logic [AW-1:0]       wr_addr, sb_addr, dbg_addr;
   logic [XLEN-1:0]     wr_data;
   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP-1:0]      rd_use;

   logic [NRP*XLEN-1:0] rd_data0, rd_data1;
   logic [NRP-1:0]      rd_pend0, rd_pend1;
   logic                stall0, stall1;
   logic [AW:0]         cnt0, cnt1;
   logic [XLEN-1:0]     dbg0, dbg1;

   reg_file_sb u_dut0 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_pend(rd_pend0),
      .rd_use(rd_use), .stall(stall0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(cnt0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
   );

   reg_file_sb #(.NREG(24), .BYPASS(0), .ZERO_R0(0)) u_dut1 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_pend(rd_pend1),
      .rd_use(rd_use), .stall(stall1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(cnt1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
   );

   // Per-DUT configuration and architectural state of the reference model.
   int unsigned cfg_nreg [NDUT] = '{32, 24};
   bit          cfg_zr0  [NDUT] = '{1'b1, 1'b0};
   bit          cfg_byp  [NDUT] = '{1'b1, 1'b0};
   logic [31:0] m_reg    [NDUT][32];
   bit          m_pend   [NDUT][32];

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        rst, we, sb;
      logic [31:0] wa, wd, sa, ra0, ra1, ru, dbg;
      logic [31:0] e_rd0, e_rd1, e_stall, e_cnt, e_dbg;
   } vec_t;
   vec_t tv [NTV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic bit m_valid(input int d, input int unsigned a);
      return (a < cfg_nreg[d]) && !(cfg_zr0[d] && (a == 0));
   endfunction

   function automatic logic [31:0] exp_rd(input int d, input int unsigned a);
      if (rst || !m_valid(d, a)) return 32'h0;
      if (cfg_byp[d] && wr_en && (32'(wr_addr) == a)) return wr_data;
      return m_reg[d][a];
   endfunction

   function automatic bit exp_pend(input int d, input int unsigned a);
      if (rst || !m_valid(d, a) || !m_pend[d][a]) return 1'b0;
      if (cfg_byp[d] && wr_en && (32'(wr_addr) == a) && !(sb_set && (32'(sb_addr) == a)))
         return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_cnt(input int d);
      int c = 0;
      for (int a = 0; a < 32; a++) c += int'(m_pend[d][a]);
      return 32'(c);
   endfunction

   // Compare every output of both DUTs with the model under the current inputs.
   task automatic check_all();
      logic [NRP*XLEN-1:0] rdv;
      logic [NRP-1:0]      pv;
      logic                sv, es;
      logic [AW:0]         cv;
      logic [XLEN-1:0]     dv, ed;
      int unsigned         a;
      for (int d = 0; d < int'(NDUT); d++) begin
         rdv = (d == 0) ? rd_data0 : rd_data1;
         pv  = (d == 0) ? rd_pend0 : rd_pend1;
         sv  = (d == 0) ? stall0   : stall1;
         cv  = (d == 0) ? cnt0     : cnt1;
         dv  = (d == 0) ? dbg0     : dbg1;
         es  = 1'b0;
         for (int p = 0; p < int'(NRP); p++) begin
            a = 32'(rd_addr[p*AW +: AW]);
            chk($sformatf("d%0d rd_data[%0d] a=%0d", d, p, a), rdv[p*XLEN +: XLEN], exp_rd(d, a));
            chk($sformatf("d%0d rd_pend[%0d] a=%0d", d, p, a), 32'(pv[p]), 32'(exp_pend(d, a)));
            es = es | (exp_pend(d, a) & rd_use[p]);
         end
         chk($sformatf("d%0d stall", d), 32'(sv), 32'(es));
         chk($sformatf("d%0d pend_cnt", d), 32'(cv), exp_cnt(d));
         ed = (rst || (32'(dbg_addr) >= cfg_nreg[d])) ? 32'h0 : m_reg[d][dbg_addr];
         chk($sformatf("d%0d dbg_data a=%0d", d, dbg_addr), dv, ed);
      end
   endtask

   // Architectural effect of one rising edge.
   task automatic model_edge();
      for (int d = 0; d < int'(NDUT); d++) begin
         if (rst) begin
            for (int a = 0; a < 32; a++) begin
               m_reg[d][a]  = 32'h0;
               m_pend[d][a] = 1'b0;
            end
         end else begin
            if (wr_en && m_valid(d, 32'(wr_addr))) begin
               m_reg[d][wr_addr]  = wr_data;
               m_pend[d][wr_addr] = 1'b0;
            end
            if (sb_set && m_valid(d, 32'(sb_addr))) m_pend[d][sb_addr] = 1'b1;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic sb, input logic [31:0] sa, input logic [31:0] ra0,
                        input logic [31:0] ra1, input logic [31:0] ru, input logic [31:0] dbg);
      rst      = r;
      wr_en    = we;
      wr_addr  = AW'(wa);
      wr_data  = wd;
      sb_set   = sb;
      sb_addr  = AW'(sa);
      rd_addr  = {AW'(ra1), AW'(ra0)};
      rd_use   = NRP'(ru);
      dbg_addr = AW'(dbg);
   endtask

   function automatic int unsigned rnd_addr();
      int unsigned r = $urandom_range(0, 9);
      if (r < 2) return 0;
      if (r < 6) return 20 + $urandom_range(0, 5);
      return $urandom_range(0, 31);
   endfunction

   initial begin
      //        rst we sb  wa  wd     sa  ra0 ra1 ru dbg | rd0    rd1 st cnt dbg
      tv[0]  = '{0, 1, 0, 21, 'h1F,  0, 21,  0, 0, 21,   'h1F,  0, 0, 0, 0};
      tv[1]  = '{0, 0, 0,  0, 0,     0, 21,  0, 0, 21,   'h1F,  0, 0, 0, 'h1F};
      tv[2]  = '{0, 1, 0, 20, 20,    0, 21, 20, 0, 21,   'h1F, 20, 0, 0, 'h1F};
      tv[3]  = '{0, 1, 0,  0, 5,     0,  0, 20, 0, 20,   0,    20, 0, 0, 20};
      tv[4]  = '{0, 0, 0,  0, 0,     0,  0, 20, 0, 20,   0,    20, 0, 0, 20};
      tv[5]  = '{0, 0, 1,  0, 0,    21, 21, 20, 1, 20,   'h1F, 20, 0, 0, 20};
      tv[6]  = '{0, 0, 0,  0, 0,     0, 21, 20, 1, 20,   'h1F, 20, 1, 1, 20};
      tv[7]  = '{0, 1, 0, 21, 'h77,  0, 21, 20, 1, 20,   'h77, 20, 0, 1, 20};
      tv[8]  = '{0, 0, 0,  0, 0,     0, 21, 20, 1, 20,   'h77, 20, 0, 0, 20};
      tv[9]  = '{0, 1, 1, 21, 'h99, 21, 21, 20, 1, 21,   'h99, 20, 0, 0, 'h77};
      tv[10] = '{0, 0, 0,  0, 0,     0, 21, 20, 1, 21,   'h99, 20, 1, 1, 'h99};
      tv[11] = '{0, 0, 1,  0, 0,    21, 21, 20, 0, 21,   'h99, 20, 0, 1, 'h99};
      tv[12] = '{0, 0, 1,  0, 0,     1, 21,  1, 3, 21,   'h99,  0, 1, 1, 'h99};
      tv[13] = '{0, 0, 1,  0, 0,     2,  1,  2, 2, 21,   0,     0, 0, 2, 'h99};
      tv[14] = '{0, 0, 1,  0, 0,     3,  1,  2, 2, 21,   0,     0, 1, 3, 'h99};
      tv[15] = '{0, 0, 1,  0, 0,     0,  3,  0, 3, 21,   0,     0, 1, 4, 'h99};
      tv[16] = '{0, 0, 0,  0, 0,     0,  0,  3, 1, 21,   0,     0, 0, 4, 'h99};
      tv[17] = '{1, 1, 1,  5, 'h55,  6, 21,  3, 3, 21,   0,     0, 0, 4, 0};
      tv[18] = '{0, 0, 0,  0, 0,     0, 21,  3, 3,  5,   0,     0, 0, 0, 0};

      // Initial reset: two edges before anything is trusted.
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
      advance();
      drive(0, 0, 0, 0, 0, 0, 21, 1, 3, 21);
      #2;
      chk("reset pend_cnt", 32'(cnt0), 32'h0);
      chk("reset stall", 32'(stall0), 32'h0);
      chk("reset rd_data", rd_data0[31:0], 32'h0);
      chk("reset dbg_data", dbg0, 32'h0);
      check_all();
      advance();

      // Directed table against the default configuration.
      for (int i = 0; i < int'(NTV); i++) begin
         drive(tv[i].rst, tv[i].we, tv[i].wa, tv[i].wd, tv[i].sb, tv[i].sa,
               tv[i].ra0, tv[i].ra1, tv[i].ru, tv[i].dbg);
         #2;
         chk($sformatf("tv%0d rd_data[0]", i), rd_data0[31:0],  tv[i].e_rd0);
         chk($sformatf("tv%0d rd_data[1]", i), rd_data0[63:32], tv[i].e_rd1);
         chk($sformatf("tv%0d stall", i),      32'(stall0),     tv[i].e_stall);
         chk($sformatf("tv%0d pend_cnt", i),   32'(cnt0),       tv[i].e_cnt);
         chk($sformatf("tv%0d dbg_data", i),   dbg0,            tv[i].e_dbg);
         if (i == 2) chk("nobypass old value", rd_data1[63:32], 32'h0);
         if (i == 4) chk("plain R0 write", rd_data1[31:0], 32'h5);
         check_all();
         advance();
      end

      // Randomized traffic, with rare resets, against the model.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
               ($urandom_range(0, 9) < 3), rnd_addr(), rnd_addr(), rnd_addr(),
               $urandom_range(0, 3), rnd_addr());
         #2;
         check_all();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
